// File: rtl/top_fifo_pkg.sv
// Shared constants and types for the top_fifo buffering block.
package top_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 32;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int DEF_ADDR_WIDTH = addr_width(DEF_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read with enable.
module fifo_mem
  import top_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/top_fifo.sv
// Single-clock 32x16 FIFO with Full/Empty/Half_Empty flags and an EN freeze.
// Define FIFO_ERR_FLAGS_EN to add sticky Overflow/Underflow outputs.
module top_fifo
  import top_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WE,
  input  logic                  RE,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [DATA_WIDTH-1:0] Read_Data,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Half_Empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  Overflow,
  output logic                  Underflow
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  write_ok, read_ok;

  // Flags come straight off the registered count.
  assign Full       = (count_q == CW'(DEPTH));
  assign Empty      = (count_q == '0);
  assign Half_Empty = (count_q <= CW'(DEPTH / 2));

  assign write_ok = ~EN & WE & ~Full;
  assign read_ok  = ~EN & RE & ~Empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (write_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (read_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({write_ok, read_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Writes are blocked during reset so the array only sees committed pushes.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (write_ok & ~Reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (Write_Data),
    .re_i    (read_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (Read_Data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (~EN & WE & Full);
    underflow_d = underflow_q | (~EN & RE & Empty);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
`endif

endmodule

// File: tb/tb_top_fifo.sv
// Directed bench for top_fifo with a queue-based reference model checked every cycle.
module tb_top_fifo;

  logic        Clock, Reset, WE, RE, EN;
  logic [15:0] Write_Data, Read_Data;
  logic        Full, Empty, Half_Empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic        Overflow, Underflow;
`endif

  top_fifo dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .WE         (WE),
    .RE         (RE),
    .EN         (EN),
    .Write_Data (Write_Data),
    .Read_Data  (Read_Data),
    .Full       (Full),
    .Empty      (Empty),
    .Half_Empty (Half_Empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .Overflow   (Overflow),
    .Underflow  (Underflow)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference model: contents as a queue, plus the last popped word and sticky errors.
  logic [15:0] mq[$];
  logic [15:0] m_rd  = '0;
  bit          m_ovf = 0;
  bit          m_unf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("Empty", Empty, mq.size() == 0);
      chk("Full", Full, mq.size() == 32);
      chk("Half_Empty", Half_Empty, mq.size() <= 16);
      chk("Read_Data", Read_Data, m_rd);
`ifdef FIFO_ERR_FLAGS_EN
      chk("Overflow", Overflow, m_ovf);
      chk("Underflow", Underflow, m_unf);
`endif
    end
  end

  task automatic step(input logic we, input logic re, input logic en, input logic rst,
                      input logic [15:0] wd);
    bit was_full, was_empty;
    WE = we; RE = re; EN = en; Reset = rst; Write_Data = wd;
    @(posedge Clock);
    was_full  = (mq.size() == 32);
    was_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_rd = '0; m_ovf = 0; m_unf = 0;
    end else if (!en) begin
      if (we && was_full)  m_ovf = 1;
      if (re && was_empty) m_unf = 1;
      if (re && !was_empty) m_rd = mq.pop_front();
      if (we && !was_full) mq.push_back(wd);
    end
    #1;
  endtask

  logic [15:0] pat [7] = '{16'h0100, 16'h1050, 16'h2000, 16'h4800, 16'h0070, 16'h6835, 16'h4115};

  initial begin
    WE = 0; RE = 0; EN = 0; Reset = 1; Write_Data = '0;
    step(0, 0, 1, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    chk_en = 1;
    step(0, 0, 0, 0, 16'h0);
    chk("lit_reset_empty", Empty, 1);
    chk("lit_reset_full", Full, 0);
    chk("lit_reset_half", Half_Empty, 1);
    chk("lit_reset_rd", Read_Data, 16'h0000);

    // Frozen writes must not land.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 16'hAAAA);
    chk("lit_frozen_empty", Empty, 1);

    // Fill past full; the 33rd word is dropped.
    for (int i = 0; i < 33; i++) begin
      step(1, 0, 0, 0, pat[i % 7]);
      if (i == 15) chk("lit_half_at16", Half_Empty, 1);
      if (i == 16) chk("lit_half_at17", Half_Empty, 0);
      if (i == 30) chk("lit_notfull_31", Full, 0);
      if (i == 31) chk("lit_full_32", Full, 1);
    end
`ifdef FIFO_ERR_FLAGS_EN
    chk("lit_overflow", Overflow, 1);
`endif

    // Drain and keep reading past empty.
    for (int i = 0; i < 97; i++) begin
      step(0, 1, 0, 0, 16'h0);
      if (i == 0)  chk("lit_read1", Read_Data, 16'h0100);
      if (i == 1)  chk("lit_read2", Read_Data, 16'h1050);
      if (i == 31) chk("lit_read32", Read_Data, 16'h4800);
      if (i == 31) chk("lit_empty_32", Empty, 1);
      if (i == 96) chk("lit_read97_hold", Read_Data, 16'h4800);
    end
`ifdef FIFO_ERR_FLAGS_EN
    chk("lit_underflow", Underflow, 1);
`endif

    // Concurrent push/pop at half occupancy.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 16'h0300 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 16'h0500 + 16'(i));
      if (i == 0) chk("lit_rw_first", Read_Data, 16'h0300);
      if (i == 9) chk("lit_rw_tenth", Read_Data, 16'h0309);
    end
    chk("lit_rw_half", Half_Empty, 1);
    chk("lit_rw_notempty", Empty, 0);

    // Frozen read holds Read_Data.
    step(0, 1, 1, 0, 16'h0);
    chk("lit_frozen_rd", Read_Data, 16'h0309);
    step(0, 1, 0, 0, 16'h0);
    chk("lit_after_freeze_rd", Read_Data, 16'h030A);

    // Empty then simultaneous WE&RE: write only, no bypass.
    step(1, 0, 0, 1, 16'h0);
    step(1, 1, 0, 0, 16'h7777);
    chk("lit_no_bypass", Read_Data, 16'h0000);
    step(0, 1, 0, 0, 16'h0);
    chk("lit_after_empty_rw", Read_Data, 16'h7777);

    // Reset mid-stream, then reuse.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'h0C00 + 16'(i));
    step(1, 1, 1, 1, 16'hDEAD);
    chk("lit_midrst_empty", Empty, 1);
    chk("lit_midrst_rd", Read_Data, 16'h0000);
    step(1, 0, 0, 0, 16'hBEEF);
    step(0, 1, 0, 0, 16'h0);
    chk("lit_post_rst_rd", Read_Data, 16'hBEEF);
    chk("lit_post_rst_empty", Empty, 1);

    step(0, 0, 0, 0, 16'h0);
    @(negedge Clock);
    #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top_fifo.md
Name: top_fifo

Overview:
- Synchronous single-clock FIFO with 16-bit data, 32 entries deep.
- Status flags: Full, Empty, Half_Empty.
- Top-level buffering block between a write-side producer and a read-side consumer.
- Global EN input freezes all state when asserted.

Parameters:
- DATA_WIDTH, 16, width of Write_Data/Read_Data.
- DEPTH, 32, number of entries; must be a power of two, >= 4.
- ADDR_WIDTH, $clog2(DEPTH) = 5, pointer width; internal occupancy count is ADDR_WIDTH+1 bits.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- WE  input  1  write request; Write_Data is pushed on the clock edge.
- RE  input  1  read request; head entry is popped to Read_Data on the clock edge.
- EN  input  1  freeze, active-high; when 1, the FIFO ignores WE/RE and holds all state.
- Write_Data  input  DATA_WIDTH  data to push.
- Read_Data  output  DATA_WIDTH  registered pop data.
- Full  output  1  count == DEPTH.
- Empty  output  1  count == 0.
- Half_Empty  output  1  count <= DEPTH/2.

Behaviour:
- One clock: Clock. Reset is synchronous and active-high; the port is named Reset. Reset has priority over EN, WE and RE.
- Reset values:
  - wr_ptr = rd_ptr = count = 0
  - Read_Data = 0
  - Empty = 1, Full = 0, Half_Empty = 1
  - memory contents are not cleared
- EN = 1 (not in reset): pointers, count, memory and Read_Data all hold; WE/RE are ignored.
- EN = 0:
  - write_ok = WE & ~Full
  - read_ok = RE & ~Empty
  - Both use the flag values before the edge.
- write_ok: mem[wr_ptr] <= Write_Data; wr_ptr increments, wrapping modulo DEPTH.
- read_ok: Read_Data <= mem[rd_ptr]; rd_ptr increments, wrapping modulo DEPTH.
  - One-cycle latency: data appears after the edge on which RE is sampled.
  - Read_Data holds its value when there is no successful read.
- Count update: +1 on write only, -1 on read only, unchanged when both occur.
- WE & RE when neither full nor empty: both happen in the same cycle.
- WE & RE when Full: read only; the write is dropped.
- WE & RE when Empty: write only; no read, Read_Data holds. No write-through bypass.
- Write when Full is silently discarded. Read when Empty is ignored.
- Flags are derived combinationally from the registered count, so they are valid one edge after the change that caused them.
- Reset asserted mid-operation empties the FIFO on that edge; data in flight is lost.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- With the macro defined, two extra outputs are added:
  - Overflow, 1 bit: sticky; set when WE=1 & Full=1 & EN=0 at a clock edge.
  - Underflow, 1 bit: sticky; set when RE=1 & Empty=1 & EN=0 at a clock edge.
  - Both are cleared only by Reset.
- Without the macro: these ports and their logic do not exist; overflow/underflow behaviour is otherwise identical (silently ignored).

Decomposition:
- Package top_fifo_pkg:
  - DATA_WIDTH and DEPTH default constants.
  - typedef data_t as logic [DATA_WIDTH-1:0].
  - ADDR_WIDTH derivation.
- One sub-module, fifo_mem:
  - Simple dual-port register array, DEPTH x DATA_WIDTH.
  - Synchronous write port, synchronous registered read port with read enable.
- top_fifo holds pointers, count, flags and control.

Test Plan:
- Reset, then idle -> Empty=1, Full=0, Half_Empty=1, Read_Data=0x0000.
- EN=1, WE=1 for 3 cycles with Write_Data=0xAAAA -> no change: Empty stays 1, count 0.
- EN=0, WE=1, write 33 words cycling 0x0100,0x1050,0x2000,0x4800,0x0070,0x6835,0x4115:
  - Half_Empty=1 after 16 writes, 0 after the 17th.
  - Full=1 after the 32nd write.
  - 33rd word (0x0070) dropped; Overflow=1 when FIFO_ERR_FLAGS_EN is defined.
- WE=0, RE=1 for 97 cycles:
  - Reads 1..32 return 0x0100,0x1050,...; read 32 returns 0x4800.
  - Empty=1 after the 32nd read.
  - Reads 33..97: Read_Data holds 0x4800; Underflow=1 when enabled.
- At 16 entries, WE=RE=1 for 10 cycles -> count stays 16, Half_Empty=1, data ordering preserved.
- Write 5 words, assert Reset mid-stream -> next edge gives Empty=1, Read_Data=0; a following write then read returns the new word.
